crop_job_sequencer: RTL and testbench
=====================================

// Module: crop_job_sequencer
// PURPOSE
//  Top-level controller for one image crop job. Accepts a crop window, validates it, writes the 54-byte
//  BMP header for the cropped image, then starts the cropping engine and waits for it to finish.
//  Owns the single memory write port and muxes it between its own header writer and the cropping engine.
//  Sits between the job source (host/UI logic) and the cropping engine plus output image memory.
// PARAMETERS
//  WIDTH        100      source image width in pixels; the crop window must lie inside it
//  HEIGHT       100      source image height in pixels
//  HDR_BASE     0        first output-memory address of the header (one header byte per address)
//  CROP_TIMEOUT 1048576  max cycles in CROP_WAIT before the job is aborted with an error
// PORTS
//  clk          in   1   clock
//  rst_n        in   1   asynchronous active-low reset
//  job_valid    in   1   a job request is presented on x_min..y_max
//  job_ready    out  1   sequencer can accept a job (high only in IDLE)
//  x_min,x_max  in   11  crop columns, inclusive
//  y_min,y_max  in   11  crop rows, inclusive
//  job_done     out  1   one-cycle pulse at job end
//  job_err      out  1   valid with job_done: 1 = window rejected or engine timeout
//  crop_start   out  1   start pulse to the cropping engine
//  crop_done    in   1   done level from the cropping engine
//  crop_xmin..crop_ymax out 11 each  latched window driven to the engine, stable from CHECK to job end
//  crop_waddr   in   24  engine write address;  crop_wdata in 16;  crop_wren in 1
//  mem_waddr    out  24  output memory write address
//  mem_wdata    out  16  output memory write data (header bytes zero-extended)
//  mem_wren     out  1   output memory write enable
// BEHAVIOUR
//  Reset (asynchronous): state=IDLE; job_ready=1; job_done=0, job_err=0, crop_start=0, mem_wren=0,
//   mem_waddr=0, mem_wdata=0; latched window=0. Reset mid-job abandons the job with no done pulse.
//  Handshake: job accepted on the clk edge where job_valid && job_ready; inputs are sampled only then.
//  States:
//   IDLE       -> CHECK on accept; latch window.
//   CHECK      1 cycle. Reject if x_min>x_max, y_min>y_max, x_max>=WIDTH or y_max>=HEIGHT -> DONE (err=1).
//              Otherwise compute w=x_max-x_min+1, h=y_max-y_min+1 (12-bit), stride=(3*w+3)&~3,
//              img=stride*h, file=54+img (32-bit, registered) -> HDR.
//   HDR        54 cycles, index i=0..53: mem_wren=1, mem_waddr=HDR_BASE+i, mem_wdata={8'h0,byte(i)};
//              after i=53 -> START. Bytes (multi-byte fields little-endian): 0-1 "BM"; 2-5 file;
//              6-9 0; 10-13 54; 14-17 40; 18-21 w; 22-25 h; 26-27 1; 28-29 24; 30-33 0;
//              34-37 img; 38-41 2835; 42-45 2835; 46-53 0.
//   START      crop_start=1 for exactly one cycle -> WAIT.
//   WAIT       mem_* = crop_* combinationally (zero latency). An internal arm flag clears on entry
//              and sets on the first cycle crop_done==0; completion = crop_done==1 with arm set
//              (a stale done level left from the previous job is ignored) -> DONE (err=0).
//              Cycle counter reaching CROP_TIMEOUT -> DONE (err=1).
//   DONE       job_done=1 one cycle, job_err per above -> IDLE.
//  mem_wren=0 and crop_wren ignored in every state except HDR and WAIT.
//  Simultaneous job_valid during a busy job: not accepted; requester must hold until job_ready.
//  Degenerate window (single pixel, x_min==x_max and y_min==y_max) is legal: w=h=1, stride=4.
// STRUCTURE
//  Package crop_pkg: state enum, BMP_HDR_BYTES=54, BMP_DIB_SIZE=40, BMP_PPM=2835, BMP_BPP=24.
//  Sub-module bmp_header_gen: combinational byte(i) from i, w, h, img, file; rest lives in this module.
// TESTING
//  1 WIDTH=HEIGHT=100, job x=10..19 y=20..29 -> 54 writes at 0..53; bytes 2..5 = 76 01 00 00,
//    18=0A, 22=0A, 34..35 = 40 01; crop_start pulses once; job_done with err=0 after engine done.
//  2 job x_max=100 -> job_done pulse with job_err=1 two cycles after accept; mem_wren never high.
//  3 job x=0..3 y=5..5 -> stride 12: bytes 2=42, 34=0C; single-pixel job x=7..7 y=7..7 -> 34=04.
//  4 crop_done held high from prior job at START -> no job_done until done falls then rises.
//  5 rst_n low during HDR at i=20 -> mem_wren=0 immediately (async); after release job_ready=1, no done.
//  6 engine never asserts done, CROP_TIMEOUT=64 -> job_done with job_err=1 64 cycles into WAIT.

Source files
------------

// File: rtl/crop_pkg.sv
// Shared types and BMP header constants for the crop job sequencer.
package crop_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StHdr,
    StStart,
    StWait,
    StDone
  } state_e;

  localparam int unsigned BMP_HDR_BYTES = 54;
  localparam int unsigned BMP_DIB_SIZE  = 40;
  localparam int unsigned BMP_PPM       = 2835;
  localparam int unsigned BMP_BPP       = 24;

  // Little-endian byte k of a 32-bit header field.
  function automatic logic [7:0] le_byte(input logic [31:0] v, input logic [1:0] k);
    return v[8*k +: 8];
  endfunction

endpackage

// File: rtl/bmp_header_gen.sv
// Combinational BMP header byte lookup: byte index in, header byte out.
module bmp_header_gen
  import crop_pkg::*;
(
  input  logic [5:0]  idx,
  input  logic [11:0] w,
  input  logic [11:0] h,
  input  logic [31:0] img,
  input  logic [31:0] file,
  output logic [7:0]  hdr_byte
);

  logic [1:0] k;

  always_comb begin
    // Every multi-byte field starts at an address that is 2 mod 4.
    k        = idx[1:0] + 2'd2;
    hdr_byte = 8'h00;
    if (idx == 6'd0) begin
      hdr_byte = 8'h42;
    end else if (idx == 6'd1) begin
      hdr_byte = 8'h4D;
    end else if (idx <= 6'd5) begin
      hdr_byte = le_byte(file, k);
    end else if (idx <= 6'd9) begin
      hdr_byte = 8'h00;
    end else if (idx <= 6'd13) begin
      hdr_byte = le_byte(32'(BMP_HDR_BYTES), k);
    end else if (idx <= 6'd17) begin
      hdr_byte = le_byte(32'(BMP_DIB_SIZE), k);
    end else if (idx <= 6'd21) begin
      hdr_byte = le_byte(32'(w), k);
    end else if (idx <= 6'd25) begin
      hdr_byte = le_byte(32'(h), k);
    end else if (idx <= 6'd29) begin
      // planes (16 bit) followed by bits-per-pixel (16 bit)
      hdr_byte = le_byte({16'(BMP_BPP), 16'd1}, k);
    end else if (idx <= 6'd33) begin
      hdr_byte = 8'h00;
    end else if (idx <= 6'd37) begin
      hdr_byte = le_byte(img, k);
    end else if (idx <= 6'd45) begin
      hdr_byte = le_byte(32'(BMP_PPM), k);
    end else begin
      hdr_byte = 8'h00;
    end
  end

endmodule

// File: rtl/crop_job_sequencer.sv
// Crop job controller: validates the window, writes the BMP header, then runs the
// cropping engine and owns the output memory write port.
module crop_job_sequencer
  import crop_pkg::*;
#(
  parameter int unsigned WIDTH        = 100,
  parameter int unsigned HEIGHT       = 100,
  parameter int unsigned HDR_BASE     = 0,
  parameter int unsigned CROP_TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [10:0] x_min,
  input  logic [10:0] x_max,
  input  logic [10:0] y_min,
  input  logic [10:0] y_max,
  output logic        job_done,
  output logic        job_err,
  output logic        crop_start,
  input  logic        crop_done,
  output logic [10:0] crop_xmin,
  output logic [10:0] crop_xmax,
  output logic [10:0] crop_ymin,
  output logic [10:0] crop_ymax,
  input  logic [23:0] crop_waddr,
  input  logic [15:0] crop_wdata,
  input  logic        crop_wren,
  output logic [23:0] mem_waddr,
  output logic [15:0] mem_wdata,
  output logic        mem_wren
);

  localparam int unsigned TMO_W = (CROP_TIMEOUT > 1) ? $clog2(CROP_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CROP_TIMEOUT - 1);
  localparam logic [5:0] HDR_LAST = 6'(BMP_HDR_BYTES - 1);

  state_e           state_q;
  logic [5:0]       idx_q;
  logic [11:0]      w_q, h_q;
  logic [31:0]      img_q, file_q;
  logic             arm_q;
  logic [TMO_W-1:0] tmo_q;

  logic [11:0] w_c, h_c;
  logic [13:0] stride_c;
  logic [31:0] img_c;
  logic        bad_c;
  logic [7:0]  hdr_byte;

  // Geometry of the latched window, consumed in CHECK.
  always_comb begin
    w_c      = {1'b0, crop_xmax} - {1'b0, crop_xmin} + 12'd1;
    h_c      = {1'b0, crop_ymax} - {1'b0, crop_ymin} + 12'd1;
    stride_c = (14'(w_c) * 14'd3 + 14'd3) & ~14'd3;
    img_c    = 32'(stride_c) * 32'(h_c);
    bad_c    = (crop_xmin > crop_xmax) || (crop_ymin > crop_ymax) ||
               (32'(crop_xmax) >= WIDTH) || (32'(crop_ymax) >= HEIGHT);
  end

  bmp_header_gen u_hdr (
    .idx      (idx_q),
    .w        (w_q),
    .h        (h_q),
    .img      (img_q),
    .file     (file_q),
    .hdr_byte (hdr_byte)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      job_ready  <= 1'b1;
      job_done   <= 1'b0;
      job_err    <= 1'b0;
      crop_start <= 1'b0;
      crop_xmin  <= '0;
      crop_xmax  <= '0;
      crop_ymin  <= '0;
      crop_ymax  <= '0;
      idx_q      <= '0;
      w_q        <= '0;
      h_q        <= '0;
      img_q      <= '0;
      file_q     <= '0;
      arm_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      job_done   <= 1'b0;
      job_err    <= 1'b0;
      crop_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (job_valid) begin
            crop_xmin <= x_min;
            crop_xmax <= x_max;
            crop_ymin <= y_min;
            crop_ymax <= y_max;
            job_ready <= 1'b0;
            state_q   <= StCheck;
          end
        end
        StCheck: begin
          if (bad_c) begin
            job_done <= 1'b1;
            job_err  <= 1'b1;
            state_q  <= StDone;
          end else begin
            w_q     <= w_c;
            h_q     <= h_c;
            img_q   <= img_c;
            file_q  <= img_c + 32'(BMP_HDR_BYTES);
            idx_q   <= '0;
            state_q <= StHdr;
          end
        end
        StHdr: begin
          if (idx_q == HDR_LAST) begin
            crop_start <= 1'b1;
            state_q    <= StStart;
          end else begin
            idx_q <= idx_q + 6'd1;
          end
        end
        StStart: begin
          arm_q   <= 1'b0;
          tmo_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // A done level still high from the previous job must drop before it counts.
          if (crop_done && arm_q) begin
            job_done <= 1'b1;
            state_q  <= StDone;
          end else if (tmo_q == TMO_LAST) begin
            job_done <= 1'b1;
            job_err  <= 1'b1;
            state_q  <= StDone;
          end else begin
            tmo_q <= tmo_q + 1'b1;
            if (!crop_done) arm_q <= 1'b1;
          end
        end
        StDone: begin
          job_ready <= 1'b1;
          state_q   <= StIdle;
        end
        default: begin
          job_ready <= 1'b1;
          state_q   <= StIdle;
        end
      endcase
    end
  end

  // Write port mux: header writer in HDR, engine pass-through in WAIT, idle otherwise.
  always_comb begin
    mem_wren  = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state_q == StHdr) begin
      mem_wren  = 1'b1;
      mem_waddr = 24'(HDR_BASE) + 24'(idx_q);
      mem_wdata = {8'h00, hdr_byte};
    end else if (state_q == StWait) begin
      mem_wren  = crop_wren;
      mem_waddr = crop_waddr;
      mem_wdata = crop_wdata;
    end
  end

endmodule

// File: tb/tb_crop_job_sequencer.sv
// Directed self-checking bench for crop_job_sequencer.
module tb_crop_job_sequencer;

  logic        clk, rst_n;
  logic        job_valid, job_ready;
  logic [10:0] x_min, x_max, y_min, y_max;
  logic        job_done, job_err, crop_start, crop_done;
  logic [10:0] crop_xmin, crop_xmax, crop_ymin, crop_ymax;
  logic [23:0] crop_waddr, mem_waddr;
  logic [15:0] crop_wdata, mem_wdata;
  logic        crop_wren, mem_wren;

  int pass_cnt = 0;
  int total_cnt = 0;
  int wr_cnt = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  logic [7:0] cap [0:63];

  crop_job_sequencer #(
    .WIDTH        (100),
    .HEIGHT       (100),
    .HDR_BASE     (0),
    .CROP_TIMEOUT (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
    .job_done   (job_done),
    .job_err    (job_err),
    .crop_start (crop_start),
    .crop_done  (crop_done),
    .crop_xmin  (crop_xmin),
    .crop_xmax  (crop_xmax),
    .crop_ymin  (crop_ymin),
    .crop_ymax  (crop_ymax),
    .crop_waddr (crop_waddr),
    .crop_wdata (crop_wdata),
    .crop_wren  (crop_wren),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wren   (mem_wren)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe the write port and pulses mid-cycle.
  always @(negedge clk) begin
    if (mem_wren) begin
      wr_cnt = wr_cnt + 1;
      if (mem_waddr < 24'd64) cap[mem_waddr[5:0]] = mem_wdata[7:0];
    end
    if (crop_start) start_cnt = start_cnt + 1;
    if (job_done) done_cnt = done_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 64; i++) cap[i] = 8'hEE;
    wr_cnt = 0;
    start_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic run_to_start(input logic [10:0] x0, input logic [10:0] x1,
                              input logic [10:0] y0, input logic [10:0] y1, output int n);
    clear_obs();
    job_valid = 1'b1;
    x_min = x0; x_max = x1; y_min = y0; y_max = y1;
    step();
    job_valid = 1'b0;
    n = 0;
    while (!crop_start && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    job_valid = 1'b0;
    x_min = '0; x_max = '0; y_min = '0; y_max = '0;
    crop_done = 1'b0; crop_waddr = '0; crop_wdata = '0; crop_wren = 1'b0;
    #12;
    total_cnt++;
    if ({job_ready, job_done, job_err, crop_start, mem_wren} !== 5'b10000) begin
      $display("FAIL reset_ctrl: got %b exp 10000",
               {job_ready, job_done, job_err, crop_start, mem_wren});
    end else pass_cnt++;
    total_cnt++;
    if ({mem_waddr, mem_wdata, crop_xmin, crop_xmax, crop_ymin, crop_ymax} !== '0) begin
      $display("FAIL reset_data: addr %h data %h xmin %0d", mem_waddr, mem_wdata, crop_xmin);
    end else pass_cnt++;
    #10 rst_n = 1'b1;
    step();
  endtask

  task automatic test_good_job();
    int n;
    crop_wren = 1'b1; crop_waddr = 24'hABCDEF; crop_wdata = 16'h5A5A;
    run_to_start(11'd10, 11'd19, 11'd20, 11'd29, n);
    total_cnt++;
    if (n !== 55) $display("FAIL good_start_latency: got %0d exp 55", n); else pass_cnt++;
    total_cnt++;
    if ({crop_xmin, crop_xmax, crop_ymin, crop_ymax} !== {11'd10, 11'd19, 11'd20, 11'd29})
      $display("FAIL good_window: got %0d %0d %0d %0d exp 10 19 20 29",
               crop_xmin, crop_xmax, crop_ymin, crop_ymax);
    else pass_cnt++;
    total_cnt++;
    if (wr_cnt !== 54) $display("FAIL good_hdr_writes: got %0d exp 54", wr_cnt); else pass_cnt++;
    total_cnt++;
    if (mem_wren !== 1'b0) $display("FAIL good_start_wren: got %b exp 0", mem_wren);
    else pass_cnt++;
    total_cnt++;
    if ({cap[1], cap[0]} !== 16'h4D42) $display("FAIL good_bm: got %h exp 4d42", {cap[1], cap[0]});
    else pass_cnt++;
    total_cnt++;
    if ({cap[5], cap[4], cap[3], cap[2]} !== 32'h00000176)
      $display("FAIL good_file: got %h exp 00000176", {cap[5], cap[4], cap[3], cap[2]});
    else pass_cnt++;
    total_cnt++;
    if ({cap[10], cap[14], cap[18], cap[22], cap[26], cap[28]} !== 48'h36_28_0A_0A_01_18)
      $display("FAIL good_fields: got %h exp 3628 0a0a 0118",
               {cap[10], cap[14], cap[18], cap[22], cap[26], cap[28]});
    else pass_cnt++;
    total_cnt++;
    if ({cap[35], cap[34], cap[39], cap[38], cap[43], cap[42], cap[53]} !== 56'h0140_0B13_0B13_00)
      $display("FAIL good_img_ppm: got %h exp 01400b130b1300",
               {cap[35], cap[34], cap[39], cap[38], cap[43], cap[42], cap[53]});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({crop_start, mem_wren, mem_waddr, mem_wdata} !== {1'b0, 1'b1, 24'hABCDEF, 16'h5A5A})
      $display("FAIL good_wait_pass: got %b %b %h %h exp 0 1 abcdef 5a5a",
               crop_start, mem_wren, mem_waddr, mem_wdata);
    else pass_cnt++;
    crop_waddr = 24'h000123;
    #1;
    total_cnt++;
    if (mem_waddr !== 24'h000123) $display("FAIL good_zero_latency: got %h exp 000123", mem_waddr);
    else pass_cnt++;
    crop_wren = 1'b0;
    step();
    step();
    crop_done = 1'b1;
    step();
    total_cnt++;
    if ({job_done, job_err} !== 2'b10) $display("FAIL good_done: got %b exp 10", {job_done, job_err});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({job_done, job_ready, start_cnt} !== {1'b0, 1'b1, 32'd1})
      $display("FAIL good_after: done %b ready %b starts %0d exp 0 1 1", job_done, job_ready, start_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reject();
    clear_obs();
    job_valid = 1'b1;
    x_min = 11'd10; x_max = 11'd100; y_min = 11'd0; y_max = 11'd9;
    step();
    job_valid = 1'b0;
    step();
    total_cnt++;
    if ({job_done, job_err} !== 2'b11) $display("FAIL rej_xmax: got %b exp 11", {job_done, job_err});
    else pass_cnt++;
    step();
    total_cnt++;
    if ({job_done, job_ready, wr_cnt, start_cnt} !== {1'b0, 1'b1, 32'd0, 32'd0})
      $display("FAIL rej_after: done %b ready %b writes %0d starts %0d exp 0 1 0 0",
               job_done, job_ready, wr_cnt, start_cnt);
    else pass_cnt++;
    job_valid = 1'b1;
    x_min = 11'd1; x_max = 11'd2; y_min = 11'd9; y_max = 11'd5;
    step();
    job_valid = 1'b0;
    step();
    total_cnt++;
    if ({job_done, job_err} !== 2'b11) $display("FAIL rej_yorder: got %b exp 11", {job_done, job_err});
    else pass_cnt++;
    step();
  endtask

  task automatic finish_engine(input string name);
    crop_done = 1'b0;
    step();
    step();
    crop_done = 1'b1;
    step();
    total_cnt++;
    if ({job_done, job_err} !== 2'b10) $display("FAIL %s_done: got %b exp 10", name, {job_done, job_err});
    else pass_cnt++;
    step();
  endtask

  task automatic test_stride();
    int n;
    run_to_start(11'd0, 11'd3, 11'd5, 11'd5, n);
    total_cnt++;
    if ({cap[2], cap[34], cap[18], cap[22]} !== 32'h42_0C_04_01)
      $display("FAIL stride12: got %h exp 420c0401", {cap[2], cap[34], cap[18], cap[22]});
    else pass_cnt++;
    step();
    finish_engine("stride12");
    run_to_start(11'd7, 11'd7, 11'd7, 11'd7, n);
    total_cnt++;
    if ({cap[2], cap[34], cap[18], cap[22]} !== 32'h3A_04_01_01)
      $display("FAIL single_px: got %h exp 3a040101", {cap[2], cap[34], cap[18], cap[22]});
    else pass_cnt++;
    step();
    finish_engine("single_px");
  endtask

  task automatic test_stale_done();
    int n;
    crop_done = 1'b1;
    run_to_start(11'd10, 11'd19, 11'd20, 11'd29, n);
    for (int i = 0; i < 6; i++) step();
    total_cnt++;
    if (done_cnt !== 0) $display("FAIL stale_ignored: got %0d done pulses exp 0", done_cnt);
    else pass_cnt++;
    crop_done = 1'b0;
    step();
    crop_done = 1'b1;
    step();
    total_cnt++;
    if ({job_done, job_err, done_cnt} !== {2'b10, 32'd0})
      $display("FAIL stale_rise: got %b prior pulses %0d exp 10 0", {job_done, job_err}, done_cnt);
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_hdr();
    clear_obs();
    crop_done = 1'b0;
    job_valid = 1'b1;
    x_min = 11'd10; x_max = 11'd19; y_min = 11'd20; y_max = 11'd29;
    step();
    job_valid = 1'b0;
    for (int i = 0; i < 21; i++) step();
    total_cnt++;
    if ({mem_wren, mem_waddr} !== {1'b1, 24'd20})
      $display("FAIL midhdr_pos: got %b %0d exp 1 20", mem_wren, mem_waddr);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({mem_wren, job_ready} !== 2'b01)
      $display("FAIL midhdr_async: got wren %b ready %b exp 0 1", mem_wren, job_ready);
    else pass_cnt++;
    step();
    step();
    #2 rst_n = 1'b1;
    done_cnt = 0;
    start_cnt = 0;
    for (int i = 0; i < 8; i++) step();
    total_cnt++;
    if ({job_ready, done_cnt, start_cnt} !== {1'b1, 32'd0, 32'd0})
      $display("FAIL midhdr_after: ready %b dones %0d starts %0d exp 1 0 0",
               job_ready, done_cnt, start_cnt);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int n;
    crop_done = 1'b0;
    run_to_start(11'd0, 11'd1, 11'd0, 11'd1, n);
    step();
    n = 0;
    while (!job_done && n < 200) begin
      step();
      n++;
    end
    total_cnt++;
    if ({n, job_err} !== {32'd64, 1'b1})
      $display("FAIL timeout: got %0d cycles err %b exp 64 1", n, job_err);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    job_valid = 1'b1;
    x_min = 11'd50; x_max = 11'd100; y_min = 11'd0; y_max = 11'd0;
    step();
    x_min = 11'd1; x_max = 11'd2; y_min = 11'd1; y_max = 11'd2;
    step();
    total_cnt++;
    if ({job_done, crop_xmin} !== {1'b1, 11'd50})
      $display("FAIL busy_hold: got done %b xmin %0d exp 1 50", job_done, crop_xmin);
    else pass_cnt++;
    step();
    step();
    total_cnt++;
    if ({job_ready, crop_xmin, crop_ymax} !== {1'b0, 11'd1, 11'd2})
      $display("FAIL busy_accept: got ready %b xmin %0d ymax %0d exp 0 1 2",
               job_ready, crop_xmin, crop_ymax);
    else pass_cnt++;
    job_valid = 1'b0;
    n = 0;
    while (!crop_start && n < 100) begin
      step();
      n++;
    end
    step();
    finish_engine("b2b");
  endtask

  initial begin
    test_reset();
    test_good_job();
    test_reject();
    test_stride();
    test_stale_done();
    test_reset_mid_hdr();
    test_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
